i2s_adc_receiver: RTL and testbench
===================================

Name: i2s_adc_receiver

Overview:
- Receive side of the codec audio link; the DAC path serialises samples onto AUD_DACDAT, this block deserialises AUD_ADCDAT.
- Oversamples the codec bit clock (AUD_BCLK), LR clock (AUD_ADCLRCK) and serial data in the system clock domain.
- Assembles left/right PCM words in I2S format (MSB one BCLK after the LRCK edge; LRCK low = left).
- Buffers stereo frames in a small FIFO and presents them on a valid/ready stream for audio_effects and later mic features.

Parameters:
SAMPLE_WIDTH, 16, bits per channel word
FIFO_DEPTH, 4, stereo frames buffered; power of two, >= 2
BITS_PER_CH, 32, BCLK periods per LRCK half-cycle; used only for frame_err checking

Ports:
clk  input  1  system clock; must be >= 4x BCLK frequency
reset_n  input  1  asynchronous active-low reset
enable  input  1  when low, the receiver ignores the link and holds the FSM in IDLE
bclk  input  1  codec bit clock (asynchronous)
lrclk  input  1  codec ADC LR clock (asynchronous)
adcdat  input  1  codec serial ADC data (asynchronous)
sample_left  output  SAMPLE_WIDTH  left word at FIFO head, two's complement
sample_right  output  SAMPLE_WIDTH  right word at FIFO head
sample_valid  output  1  FIFO non-empty
sample_ready  input  1  consumer accepts the head frame when valid&ready
fifo_level  output  $clog2(FIFO_DEPTH)+1  frames stored
overflow  output  1  sticky: a frame was dropped because the FIFO was full
frame_err  output  1  sticky: an LRCK edge arrived with fewer than SAMPLE_WIDTH bits captured, or bit count > BITS_PER_CH
clear_flags  input  1  single-cycle pulse; clears overflow and frame_err

Behaviour:
- Reset: all sync flops 0; FSM IDLE; FIFO empty; sample_valid=0, sample_left/right=0, fifo_level=0, overflow=0, frame_err=0.
- Synchronisation: bclk, lrclk and adcdat each pass through 2 flops. One extra delay flop feeds edge detection. bclk_rise is a one-clk pulse. lrclk and adcdat are sampled only on bclk_rise.
- FSM:
  - IDLE: wait for the first LRCK change seen at a bclk_rise → SKIP. Whatever frame is in progress at enable or reset is discarded.
  - SKIP: consume one BCLK (I2S one-bit delay) → SHIFT.
  - SHIFT: shift adcdat MSB-first into the channel word for SAMPLE_WIDTH bclk_rises → PAD.
  - PAD: ignore bits until the next LRCK edge, which also consumes the delay bit → SHIFT for the other channel.
- Channel select: LRCK low selects left, LRCK high selects right.
- Frame push:
  - When the right word completes, {left, right} is pushed one clk later.
  - Latency from the bclk_rise that samples the right LSB (at the pins) to sample_valid with an empty FIFO: 4 clk.
- Short word:
  - Condition: LRCK edge while in SHIFT.
  - Remaining LSBs fill with 0 and frame_err is set.
  - A right word is still pushed. The FSM restarts the new channel from SKIP.
- Long half-cycle:
  - Condition: bit counter reaches BITS_PER_CH without an LRCK edge.
  - frame_err is set; FSM → IDLE.
- FIFO: first-word fall-through; head visible while valid.
  - Pop on valid&ready. Push and pop in the same cycle are both honoured, including when full.
  - Push when full and no pop: frame dropped, overflow set, stored data untouched.
- Flags: clear_flags in the same cycle as a new error event leaves the flag set (set wins).
- enable low: FSM forced to IDLE and partial word discarded. FIFO contents and outputs are unaffected, so the consumer may drain.
- reset_n asserted mid-frame: everything returns to reset values immediately. After deassert, the first frame is pushed only after a full left+right pair.

Decomposition:
- Package i2s_pkg: typedef rx_state_t {IDLE, SKIP, SHIFT, PAD}; typedef stereo_frame_t packed struct {left, right}; localparam I2S_DELAY_BITS=1.
- One sub-module: sync_fifo (parameterised width/depth, FWFT, level output).

Test Plan:
- Codec model, BCLK = clk/8, BITS_PER_CH=32; send L=16'hA5C3, R=16'h0F0F → one frame with sample_left=A5C3, sample_right=0F0F; valid exactly 4 clk after the right-LSB bclk_rise; frame_err=0.
- ready held 0, send 6 frames (values 1..6, L=R) → fifo_level=4; frames 1–4 retained; overflow=1 after frame 5; drain yields 1,2,3,4.
- LRCK toggled after 10 bits of a left word 16'hFFFF → left=16'hFFC0 in the pushed frame; frame_err=1; clear_flags pulse → frame_err=0.
- reset_n pulsed low mid right word, then 2 clean frames (1234/5678, 9ABC/DEF0) → no partial frame; exactly those two frames out; flags 0.
- enable low for 3 LRCK periods with 2 frames buffered, ready=1 → both frames drain; no new pushes; resume on the first clean pair after enable rises.
- Continuous stream of 100 frames with ready=1 and pop/push coinciding at level 4 → no overflow; order and data exact.

Source files
------------

// File: rtl/i2s_adc_receiver_pkg.sv
// Shared types for the I2S ADC receive path: FSM state encoding and the
// stereo frame layout handed from the deserialiser to the output FIFO.
package i2s_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SKIP  = 2'd1,
        SHIFT = 2'd2,
        PAD   = 2'd3
    } rx_state_t;

    // I2S places the MSB one BCLK after the LRCK edge.
    localparam int I2S_DELAY_BITS = 1;

    localparam int PCM_WIDTH = 16;

    typedef struct packed {
        logic [PCM_WIDTH-1:0] left;
        logic [PCM_WIDTH-1:0] right;
    } stereo_frame_t;

endpackage

// File: rtl/i2s_adc_receiver_fifo.sv
// First-word-fall-through FIFO with occupancy count; a push into a full FIFO
// succeeds only if a pop is accepted in the same cycle, otherwise it is dropped.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] level,
    output logic                   drop
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign valid   = (count != '0);
    assign do_pop  = pop & valid;
    assign do_push = push & (~full | do_pop);
    assign drop    = push & full & ~do_pop;
    assign head    = mem[rd_ptr];
    assign level   = count;

    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/i2s_adc_receiver.sv
// I2S ADC deserialiser: oversamples the codec link, assembles left/right PCM
// words and queues complete stereo frames on a valid/ready stream.
module i2s_adc_receiver
    import i2s_pkg::*;
#(
    parameter int SAMPLE_WIDTH = 16,
    parameter int FIFO_DEPTH   = 4,
    parameter int BITS_PER_CH  = 32
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic                          bclk,
    input  logic                          lrclk,
    input  logic                          adcdat,
    output logic [SAMPLE_WIDTH-1:0]       sample_left,
    output logic [SAMPLE_WIDTH-1:0]       sample_right,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic                          frame_err,
    input  logic                          clear_flags
);
    localparam int CW = $clog2(SAMPLE_WIDTH + 1);
    localparam int BW = $clog2(BITS_PER_CH + 1);

    rx_state_t state, state_d;

    logic [2:0] bclk_sync;
    logic [1:0] lrclk_sync;
    logic [1:0] adc_sync;
    logic       bclk_rise, lr_now, din, lr_prev, lr_edge;

    logic [SAMPLE_WIDTH-1:0]   shreg, left_word, word_full, word_out;
    logic [CW-1:0]             bit_pos;
    logic [BW-1:0]             half_cnt;
    logic                      half_done, chan, left_ok;
    logic                      start_ch, shift_en, word_done, short_word, long_err;
    logic                      push_q, fifo_drop;
    logic [2*SAMPLE_WIDTH-1:0] frame_q, fifo_head;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bclk_sync  <= '0;
            lrclk_sync <= '0;
            adc_sync   <= '0;
        end else begin
            bclk_sync  <= {bclk_sync[1:0], bclk};
            lrclk_sync <= {lrclk_sync[0], lrclk};
            adc_sync   <= {adc_sync[0], adcdat};
        end
    end

    assign bclk_rise = bclk_sync[1] & ~bclk_sync[2];
    assign lr_now    = lrclk_sync[1];
    assign din       = adc_sync[1];
    assign lr_edge   = bclk_rise & (lr_now != lr_prev);
    assign half_done = (half_cnt == BW'(BITS_PER_CH - 1));
    assign word_full = {shreg[SAMPLE_WIDTH-2:0], din};
    // A truncated word keeps the bits received so far, MSB-aligned, zero-filled below.
    assign word_out  = short_word ? (shreg << (CW'(SAMPLE_WIDTH) - bit_pos)) : word_full;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_d;
    end

    always_comb begin
        state_d = state;
        if (!enable || long_err) state_d = IDLE;
        else if (short_word)     state_d = SKIP;
        else if (word_done)      state_d = PAD;
        else if (start_ch)       state_d = (state == IDLE) ? SKIP : SHIFT;
        else if (shift_en)       state_d = SHIFT;
    end

    // The LRCK edge rise itself is the delay bit, so the MSB lands on the following rise.
    always_comb begin
        start_ch   = 1'b0;
        shift_en   = 1'b0;
        word_done  = 1'b0;
        short_word = 1'b0;
        long_err   = 1'b0;
        if (enable && bclk_rise) begin
            case (state)
                IDLE: start_ch = lr_edge;
                SKIP, SHIFT: begin
                    if (lr_edge)        short_word = 1'b1;
                    else if (half_done) long_err   = 1'b1;
                    else begin
                        shift_en  = 1'b1;
                        word_done = (bit_pos == CW'(SAMPLE_WIDTH - 1));
                    end
                end
                PAD: begin
                    if (lr_edge)        start_ch = 1'b1;
                    else if (half_done) long_err = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lr_prev   <= 1'b0;
            chan      <= 1'b0;
            left_ok   <= 1'b0;
            shreg     <= '0;
            left_word <= '0;
            bit_pos   <= '0;
            half_cnt  <= '0;
            push_q    <= 1'b0;
            frame_q   <= '0;
        end else begin
            push_q <= 1'b0;
            if (bclk_rise) lr_prev <= lr_now;
            if (!enable || long_err) left_ok <= 1'b0;
            if (start_ch || short_word) begin
                chan     <= lr_now;
                bit_pos  <= '0;
                shreg    <= '0;
                half_cnt <= '0;
            end else if (shift_en) begin
                shreg    <= word_full;
                bit_pos  <= bit_pos + CW'(1);
                half_cnt <= half_cnt + BW'(1);
            end else if (bclk_rise && state != IDLE) begin
                half_cnt <= half_cnt + BW'(1);
            end
            // A right word only becomes a frame when a left word precedes it in this run.
            if (word_done || short_word) begin
                if (!chan) begin
                    left_word <= word_out;
                    left_ok   <= 1'b1;
                end else begin
                    push_q  <= left_ok;
                    frame_q <= {left_word, word_out};
                    left_ok <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overflow  <= fifo_drop | (overflow & ~clear_flags);
            frame_err <= short_word | long_err | (frame_err & ~clear_flags);
        end
    end

    sync_fifo #(
        .WIDTH (2 * SAMPLE_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push_q),
        .push_data (frame_q),
        .pop       (sample_ready),
        .head      (fifo_head),
        .valid     (sample_valid),
        .level     (fifo_level),
        .drop      (fifo_drop)
    );

    assign sample_left  = fifo_head[2*SAMPLE_WIDTH-1:SAMPLE_WIDTH];
    assign sample_right = fifo_head[SAMPLE_WIDTH-1:0];

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Directed + random bench: a codec model drives I2S halves at BCLK = clk/8 and
// a frame-level reference queue predicts every frame the consumer should see.
module tb_i2s_adc_receiver;
    import i2s_pkg::*;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int BPC   = 32;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         enable = 1'b0;
    logic         bclk = 1'b0;
    logic         lrclk = 1'b0;
    logic         adcdat = 1'b0;
    logic         sample_ready = 1'b0;
    logic         clear_flags = 1'b0;
    logic [W-1:0] sample_left;
    logic [W-1:0] sample_right;
    logic         sample_valid;
    logic [2:0]   fifo_level;
    logic         overflow;
    logic         frame_err;

    int            checks = 0;
    int            errors = 0;
    stereo_frame_t exp_q[$];
    logic          exp_ovf = 1'b0;
    stereo_frame_t f;

    always #5 clk = ~clk;

    i2s_adc_receiver #(
        .SAMPLE_WIDTH (W),
        .FIFO_DEPTH   (DEPTH),
        .BITS_PER_CH  (BPC)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .bclk         (bclk),
        .lrclk        (lrclk),
        .adcdat       (adcdat),
        .sample_left  (sample_left),
        .sample_right (sample_right),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fifo_level   (fifo_level),
        .overflow     (overflow),
        .frame_err    (frame_err),
        .clear_flags  (clear_flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a bounded frame queue; a frame arriving when it is full is lost.
    function automatic void model_push(input stereo_frame_t fr);
        if (exp_q.size() < DEPTH) exp_q.push_back(fr);
        else exp_ovf = 1'b1;
    endfunction

    function automatic logic [W-1:0] truncate_word(input logic [W-1:0] w, input int n);
        logic [W-1:0] mask;
        mask = '1;
        mask = mask << (W - n);
        return w & mask;
    endfunction

    // Consumer side: every accepted handshake must match the oldest predicted frame.
    always @(negedge clk) begin
        #2;
        if (reset_n && sample_valid && sample_ready) begin
            check("pop_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                check("frame_data", {sample_left, sample_right}, exp_q[0]);
                void'(exp_q.pop_front());
            end
        end
    end

    // One BCLK period starting at a clk negedge: data changes with BCLK low.
    task automatic slot(input logic lr, input logic d, input int mode);
        bclk   = 1'b0;
        lrclk  = lr;
        adcdat = d;
        repeat (4) @(negedge clk);
        bclk = 1'b1;
        if (mode == 1) begin
            repeat (3) @(posedge clk);
            #1 check("latency_early", 32'(sample_valid), 32'd0);
            @(posedge clk);
            #1 check("latency_valid", 32'(sample_valid), 32'd1);
            @(negedge clk);
        end else if (mode == 2) begin
            repeat (3) @(negedge clk);
            sample_ready = 1'b1;
            @(negedge clk);
            sample_ready = 1'b0;
        end else begin
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic send_half(input logic lr, input logic [W-1:0] word, input int nbits,
                             input int mode, input logic push_exp, input stereo_frame_t fr);
        int   nslots;
        logic d;
        nslots = (nbits < W) ? nbits + 1 : BPC;
        for (int s = 0; s < nslots; s++) begin
            d = (s >= 1 && s <= nbits) ? word[W-s] : 1'($urandom_range(0, 1));
            slot(lr, d, (s == W) ? mode : 0);
            if (s == W && push_exp) model_push(fr);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r,
                              input int mode, input logic push_exp);
        stereo_frame_t fr;
        fr.left  = l;
        fr.right = r;
        send_half(1'b0, l, W, 0, 1'b0, fr);
        send_half(1'b1, r, W, mode, push_exp, fr);
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (2) @(negedge clk);
        check(tag, 32'(exp_q.size()), 32'd0);
        check({tag, "_level"}, 32'(fifo_level), 32'd0);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        clear_flags = 1'b1;
        @(negedge clk);
        clear_flags = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        f = '0;
        repeat (4) @(negedge clk);
        check("rst_valid", 32'(sample_valid), 32'd0);
        check("rst_left", 32'(sample_left), 32'd0);
        check("rst_right", 32'(sample_right), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        enable  = 1'b1;
        @(negedge clk);

        // Single frame with latency measurement from the right-LSB BCLK rise.
        send_half(1'b1, 16'h0000, W, 0, 1'b0, f);
        send_frame(16'hA5C3, 16'h0F0F, 1, 1'b1);
        check("t1_level", 32'(fifo_level), 32'd1);
        check("t1_left", 32'(sample_left), 32'hA5C3);
        check("t1_right", 32'(sample_right), 32'h0F0F);
        check("t1_frame_err", 32'(frame_err), 32'd0);
        sample_ready = 1'b1;
        wait_drain("t1_drain");

        // Overflow: six frames into a four-deep FIFO with the consumer stalled.
        sample_ready = 1'b0;
        exp_ovf = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            send_frame(16'(i), 16'(i), 0, 1'b1);
            check("t2_overflow", 32'(overflow), 32'(exp_ovf));
        end
        check("t2_level", 32'(fifo_level), 32'd4);
        sample_ready = 1'b1;
        wait_drain("t2_drain");
        check("t2_overflow_sticky", 32'(overflow), 32'd1);
        pulse_clear();
        exp_ovf = 1'b0;
        check("t2_overflow_clear", 32'(overflow), 32'(exp_ovf));

        // Short left word: LRCK flips after 10 of 16 bits.
        f.left  = truncate_word(16'hFFFF, 10);
        f.right = 16'h3C3C;
        send_half(1'b0, 16'hFFFF, 10, 0, 1'b0, f);
        send_half(1'b1, 16'h3C3C, W, 0, 1'b1, f);
        wait_drain("t3_drain");
        check("t3_frame_err", 32'(frame_err), 32'd1);
        pulse_clear();
        check("t3_frame_err_clear", 32'(frame_err), 32'd0);

        // Reset mid right word discards the FIFO and the partial frame.
        sample_ready = 1'b0;
        send_frame(16'h1111, 16'h2222, 0, 1'b1);
        check("t4_level_pre", 32'(fifo_level), 32'd1);
        send_half(1'b0, 16'h3333, W, 0, 1'b0, f);
        send_half(1'b1, 16'h4444, 8, 0, 1'b0, f);
        bclk = 1'b0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        exp_q.delete();
        check("t4_rst_valid", 32'(sample_valid), 32'd0);
        check("t4_rst_level", 32'(fifo_level), 32'd0);
        check("t4_rst_left", 32'(sample_left), 32'd0);
        reset_n = 1'b1;
        sample_ready = 1'b1;
        @(negedge clk);
        send_half(1'b1, 16'h0000, W, 0, 1'b0, f);
        send_frame(16'h1234, 16'h5678, 0, 1'b1);
        send_frame(16'h9ABC, 16'hDEF0, 0, 1'b1);
        wait_drain("t4_drain");
        check("t4_overflow", 32'(overflow), 32'd0);
        check("t4_frame_err", 32'(frame_err), 32'd0);

        // Enable low: buffered frames still drain, link traffic is ignored.
        sample_ready = 1'b0;
        send_frame(16'hAAAA, 16'h5555, 0, 1'b1);
        send_frame(16'h0102, 16'h0304, 0, 1'b1);
        check("t5_level", 32'(fifo_level), 32'd2);
        enable = 1'b0;
        sample_ready = 1'b1;
        for (int i = 0; i < 3; i++) send_frame(16'($urandom), 16'($urandom), 0, 1'b0);
        check("t5_level_idle", 32'(fifo_level), 32'd0);
        check("t5_queue_idle", 32'(exp_q.size()), 32'd0);
        enable = 1'b1;
        send_frame(16'h7777, 16'h8888, 0, 1'b1);
        wait_drain("t5_drain");
        check("t5_frame_err", 32'(frame_err), 32'd0);

        // Push and pop coincide at full, then a long random stream.
        sample_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_frame(16'($urandom), 16'($urandom), 0, 1'b1);
        check("t6_level_full", 32'(fifo_level), 32'd4);
        send_frame(16'($urandom), 16'($urandom), 2, 1'b1);
        check("t6_level_coincide", 32'(fifo_level), 32'd4);
        check("t6_overflow_coincide", 32'(overflow), 32'd0);
        sample_ready = 1'b1;
        for (int i = 0; i < 100; i++) send_frame(16'($urandom), 16'($urandom), 0, 1'b1);
        wait_drain("t6_drain");
        check("t6_overflow", 32'(overflow), 32'(exp_ovf));
        check("t6_frame_err", 32'(frame_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
